// File: rtl/tl_user_arb.sv
// N-channel command/write-data arbiter for the TL user request path.
// Grants one channel per command, keeps its write burst atomic, forwards the channel ID.
module tl_user_arb #(
    parameter int  NUM_CH   = 4,
    parameter int  CMD_W    = 128,
    parameter int  DATA_W   = 128,
    parameter int  ARB_MODE = 0,
    parameter int  CH_W     = $clog2(NUM_CH),
    localparam int BE_W     = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*CMD_W-1:0]  s_cmd_i,
    input  logic [NUM_CH-1:0]        s_cmd_wr_i,
    input  logic [NUM_CH-1:0]        s_cmd_valid_i,
    output logic [NUM_CH-1:0]        s_cmd_ready_o,
    input  logic [NUM_CH*DATA_W-1:0] s_wdata_i,
    input  logic [NUM_CH*BE_W-1:0]   s_wbe_i,
    input  logic [NUM_CH-1:0]        s_wsop_i,
    input  logic [NUM_CH-1:0]        s_weop_i,
    input  logic [NUM_CH-1:0]        s_wvalid_i,
    output logic [NUM_CH-1:0]        s_wready_o,
    output logic [CMD_W-1:0]         m_cmd_o,
    output logic [CH_W-1:0]          m_ch_o,
    output logic                     m_cmd_valid_o,
    input  logic                     m_cmd_ready_i,
    output logic [DATA_W-1:0]        m_wdata_o,
    output logic [BE_W-1:0]          m_wbe_o,
    output logic                     m_wsop_o,
    output logic                     m_weop_o,
    output logic                     m_wvalid_o,
    input  logic                     m_wready_i,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [7:0]               err_cnt_o
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_ch;
    logic [CMD_W-1:0]  r_cmd;
    logic              r_cmd_valid;
    logic              r_wr;
    logic              r_first;
    logic              r_err;
    logic [7:0]        r_err_cnt;

    logic [CMD_W-1:0]  w_cmd_arr   [NUM_CH];
    logic [DATA_W-1:0] w_wdata_arr [NUM_CH];
    logic [BE_W-1:0]   w_wbe_arr   [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign w_cmd_arr[k]   = s_cmd_i[k*CMD_W +: CMD_W];
        assign w_wdata_arr[k] = s_wdata_i[k*DATA_W +: DATA_W];
        assign w_wbe_arr[k]   = s_wbe_i[k*BE_W +: BE_W];
    end

    // Two passes: requesters at/after the pointer first, then the wrapped-around ones.
    logic            w_any_req;
    logic [CH_W-1:0] w_gnt;

    // NOTE: every always_comb output gets a default before any conditional write, so no latch can form.
    always_comb begin
        w_any_req = 1'b0;
        w_gnt     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!w_any_req && s_cmd_valid_i[c] && (ARB_MODE == 1 || CH_W'(c) >= r_rr_ptr)) begin
                w_any_req = 1'b1;
                w_gnt     = CH_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!w_any_req && s_cmd_valid_i[c]) begin
                w_any_req = 1'b1;
                w_gnt     = CH_W'(c);
            end
        end
    end

    logic w_in_data;
    logic w_beat;

    assign w_in_data  = (r_state == DATA);
    assign m_wdata_o  = w_wdata_arr[r_ch];
    assign m_wbe_o    = w_wbe_arr[r_ch];
    assign m_wsop_o   = s_wsop_i[r_ch];
    assign m_weop_o   = s_weop_i[r_ch];
    assign m_wvalid_o = w_in_data && s_wvalid_i[r_ch];
    assign w_beat     = m_wvalid_o && m_wready_i;

    // Ready is masked while reset is held so nothing is handed over during reset.
    always_comb begin
        s_cmd_ready_o = '0;
        s_wready_o    = '0;
        if (r_state == IDLE && w_any_req && !rst_n)
            s_cmd_ready_o[w_gnt] = 1'b1;
        if (w_in_data)
            s_wready_o[r_ch] = m_wready_i;
    end

    assign m_cmd_o       = r_cmd;
    assign m_ch_o        = r_ch;
    assign m_cmd_valid_o = r_cmd_valid;
    assign busy_o        = (r_state != IDLE);
    assign err_o         = r_err;
    assign err_cnt_o     = r_err_cnt;

    // NOTE: rst_n is active-high in this codebase: the block is held in reset while it reads 1.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_ch        <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_wr        <= 1'b0;
            r_first     <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_cmd       <= w_cmd_arr[w_gnt];
                        r_ch        <= w_gnt;
                        r_wr        <= s_cmd_wr_i[w_gnt];
                        r_cmd_valid <= 1'b1;
                        r_state     <= CMD;
                        if (ARB_MODE == 0)
                            r_rr_ptr <= (w_gnt == CH_W'(NUM_CH - 1)) ? '0 : w_gnt + CH_W'(1);
                    end
                end
                CMD: begin
                    if (m_cmd_ready_i) begin
                        r_cmd_valid <= 1'b0;
                        r_first     <= 1'b1;
                        r_state     <= r_wr ? DATA : IDLE;
                    end
                end
                DATA: begin
                    // err_o pulses in the cycle after the offending beat; the beat itself passes untouched.
                    if (w_beat) begin
                        if (s_wsop_i[r_ch] != r_first) begin
                            r_err <= 1'b1;
                            if (r_err_cnt != 8'hFF)
                                r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_first <= 1'b0;
                        if (s_weop_i[r_ch])
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_user_arb.sv
// Self-checking bench for tl_user_arb: directed scenarios plus randomized traffic
// checked every cycle against a behavioural arbiter model.
module tb_tl_user_arb;

    localparam int NC  = 4;
    localparam int CW  = 16;
    localparam int DW  = 16;
    localparam int BW  = DW / 8;
    localparam int CHW = 2;
    localparam int MAXB = 8;
    localparam int P_IDLE = 0, P_CMD = 1, P_DATA = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC*CW-1:0] s_cmd = '0;
    logic [NC-1:0]    s_cmd_wr = '0, s_cmd_valid = '0;
    logic [NC*DW-1:0] s_wdata = '0;
    logic [NC*BW-1:0] s_wbe = '0;
    logic [NC-1:0]    s_wsop = '0, s_weop = '0, s_wvalid = '0;
    logic             m_cmd_ready = 1'b0, m_wready = 1'b0;

    logic [NC-1:0]  cmd_ready0, wready0, cmd_ready1, wready1;
    logic [CW-1:0]  m_cmd0, m_cmd1;
    logic [CHW-1:0] m_ch0, m_ch1;
    logic           m_cmd_valid0, m_cmd_valid1;
    logic [DW-1:0]  m_wdata0, m_wdata1;
    logic [BW-1:0]  m_wbe0, m_wbe1;
    logic           m_wsop0, m_weop0, m_wvalid0, busy0, err0;
    logic           m_wsop1, m_weop1, m_wvalid1, busy1, err1;
    logic [7:0]     err_cnt0, err_cnt1;

    tl_user_arb #(.NUM_CH(NC), .CMD_W(CW), .DATA_W(DW), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .s_cmd_i(s_cmd), .s_cmd_wr_i(s_cmd_wr), .s_cmd_valid_i(s_cmd_valid), .s_cmd_ready_o(cmd_ready0),
        .s_wdata_i(s_wdata), .s_wbe_i(s_wbe), .s_wsop_i(s_wsop), .s_weop_i(s_weop),
        .s_wvalid_i(s_wvalid), .s_wready_o(wready0),
        .m_cmd_o(m_cmd0), .m_ch_o(m_ch0), .m_cmd_valid_o(m_cmd_valid0), .m_cmd_ready_i(m_cmd_ready),
        .m_wdata_o(m_wdata0), .m_wbe_o(m_wbe0), .m_wsop_o(m_wsop0), .m_weop_o(m_weop0),
        .m_wvalid_o(m_wvalid0), .m_wready_i(m_wready),
        .busy_o(busy0), .err_o(err0), .err_cnt_o(err_cnt0)
    );

    tl_user_arb #(.NUM_CH(NC), .CMD_W(CW), .DATA_W(DW), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .s_cmd_i(s_cmd), .s_cmd_wr_i(s_cmd_wr), .s_cmd_valid_i(s_cmd_valid), .s_cmd_ready_o(cmd_ready1),
        .s_wdata_i(s_wdata), .s_wbe_i(s_wbe), .s_wsop_i(s_wsop), .s_weop_i(s_weop),
        .s_wvalid_i(s_wvalid), .s_wready_o(wready1),
        .m_cmd_o(m_cmd1), .m_ch_o(m_ch1), .m_cmd_valid_o(m_cmd_valid1), .m_cmd_ready_i(m_cmd_ready),
        .m_wdata_o(m_wdata1), .m_wbe_o(m_wbe1), .m_wsop_o(m_wsop1), .m_weop_o(m_weop1),
        .m_wvalid_o(m_wvalid1), .m_wready_i(m_wready),
        .busy_o(busy1), .err_o(err1), .err_cnt_o(err_cnt1)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-channel traffic sources.
    logic          c_pend [NC];
    logic [CW-1:0] c_cmd  [NC];
    logic          c_wr   [NC];
    int            nb     [NC];
    int            bi     [NC];
    logic [DW-1:0] b_data [NC][MAXB];
    logic [BW-1:0] b_be   [NC][MAXB];
    logic          b_sop  [NC][MAXB];
    logic          b_eop  [NC][MAXB];

    int   pol_rand = 0, pol_fair = 0;
    int   cr_mode = 1, wr_mode = 1, wv_pct = 100;
    logic tog = 1'b0;

    // Reference model state: phase of the transfer, owner, pointer, error count.
    int            ph = P_IDLE, mch = 0, mptr = 0, mcnt = 0;
    logic [CW-1:0] mcmd = '0;
    logic          mwr = 1'b0, mfirst = 1'b0, merr = 1'b0;

    int obs_beats = 0, obs_eop_at = 0, obs_err = 0, fair_k = 0;

    function automatic int pick(input logic [NC-1:0] req, input int ptr);
        for (int i = 0; i < NC; i++)
            if (req[(ptr + i) % NC]) return (ptr + i) % NC;
        return -1;
    endfunction

    function automatic int outstanding();
        int n = (ph != P_IDLE) ? 1 : 0;
        for (int c = 0; c < NC; c++) n += int'(c_pend[c]) + (nb[c] - bi[c]);
        return n;
    endfunction

    task automatic queue_cmd(input int c, input logic wr, input int n, input int bad);
        c_pend[c] = 1'b1;
        c_cmd[c]  = CW'($urandom);
        c_wr[c]   = wr;
        nb[c]     = wr ? n : 0;
        bi[c]     = 0;
        for (int k = 0; k < MAXB; k++) begin
            b_data[c][k] = DW'($urandom);
            b_be[c][k]   = BW'($urandom);
            b_sop[c][k]  = (k == 0) ^ (k == bad);
            b_eop[c][k]  = (k == n - 1);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < NC; c++) begin
            int k = (bi[c] < nb[c]) ? bi[c] : 0;
            s_cmd_valid[c]       = c_pend[c];
            s_cmd[c*CW +: CW]    = c_cmd[c];
            s_cmd_wr[c]          = c_wr[c];
            s_wvalid[c]          = (bi[c] < nb[c]) && ($urandom_range(99) < wv_pct);
            s_wdata[c*DW +: DW]  = b_data[c][k];
            s_wbe[c*BW +: BW]    = b_be[c][k];
            s_wsop[c]            = b_sop[c][k];
            s_weop[c]            = b_eop[c][k];
        end
        case (cr_mode)
            0:       m_cmd_ready = 1'($urandom_range(1));
            1:       m_cmd_ready = 1'b1;
            default: m_cmd_ready = 1'b0;
        endcase
        tog = ~tog;
        case (wr_mode)
            0:       m_wready = 1'($urandom_range(1));
            1:       m_wready = 1'b1;
            3:       m_wready = tog;
            default: m_wready = 1'b0;
        endcase
    endtask

    task automatic check_model();
        int g;
        logic [NC-1:0] er, ew;
        g  = pick(s_cmd_valid, mptr);
        er = '0;
        ew = '0;
        if (ph == P_IDLE && g >= 0) er[g] = 1'b1;
        if (ph == P_DATA) ew[mch] = m_wready;
        check("cmd_ready", cmd_ready0, er);
        check("wready", wready0, ew);
        check("busy", busy0, ph != P_IDLE);
        check("cmd_valid", m_cmd_valid0, ph == P_CMD);
        check("err", err0, merr);
        check("err_cnt", err_cnt0, mcnt);
        if (ph == P_CMD) begin
            check("m_cmd", m_cmd0, mcmd);
            check("m_ch", m_ch0, mch);
        end
        check("wvalid", m_wvalid0, ph == P_DATA && s_wvalid[mch]);
        if (ph == P_DATA && s_wvalid[mch]) begin
            check("wdata", m_wdata0, s_wdata[mch*DW +: DW]);
            check("wbe", m_wbe0, s_wbe[mch*BW +: BW]);
            check("wsop", m_wsop0, s_wsop[mch]);
            check("weop", m_weop0, s_weop[mch]);
        end
        merr = 1'b0;
        case (ph)
            P_IDLE: if (g >= 0) begin
                mcmd = s_cmd[g*CW +: CW];
                mch  = g;
                mwr  = s_cmd_wr[g];
                mptr = (g + 1) % NC;
                ph   = P_CMD;
            end
            P_CMD: if (m_cmd_ready) begin
                mfirst = 1'b1;
                ph     = mwr ? P_DATA : P_IDLE;
            end
            default: if (s_wvalid[mch] && m_wready) begin
                if (s_wsop[mch] != mfirst) begin
                    merr = 1'b1;
                    if (mcnt < 255) mcnt++;
                end
                mfirst = 1'b0;
                if (s_weop[mch]) ph = P_IDLE;
            end
        endcase
    endtask

    task automatic update_driver();
        for (int c = 0; c < NC; c++) begin
            if (c_pend[c] && cmd_ready0[c])
                c_pend[c] = 1'b0;
            else if (c_pend[c] && !c_wr[c] && pol_rand != 0 && $urandom_range(15) == 0)
                c_pend[c] = 1'b0;
            if (s_wvalid[c] && wready0[c]) bi[c]++;
            if (!c_pend[c] && bi[c] >= nb[c]) begin
                if (pol_fair != 0)
                    queue_cmd(c, 1'b0, 0, -1);
                else if (pol_rand != 0 && $urandom_range(3) == 0)
                    queue_cmd(c, 1'($urandom_range(1)), int'($urandom_range(1, 4)),
                              ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1);
            end
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        if (m_wvalid0 && m_wready) begin
            obs_beats++;
            if (m_weop0) obs_eop_at = obs_beats;
        end
        if (err0) obs_err++;
        if (pol_fair != 0) begin
            if (m_cmd_valid0) begin
                check("rr_order", m_ch0, fair_k % NC);
                fair_k++;
            end
            if (m_cmd_valid1) check("fixed_prio", m_ch1, 0);
        end
        check_model();
        update_driver();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while (outstanding() != 0 && n < limit) begin
            cycle();
            n++;
        end
        check(tag, outstanding(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        for (int c = 0; c < NC; c++) begin
            c_pend[c] = 1'b0; c_wr[c] = 1'b0; c_cmd[c] = '0; nb[c] = 0; bi[c] = 0;
        end
        pol_rand = 0; pol_fair = 0;
        s_cmd_valid = '1; s_wvalid = '1; m_wready = 1'b1; m_cmd_ready = 1'b1;
        #1;
        check("rst_busy", busy0, 0);
        check("rst_cmd_valid", m_cmd_valid0, 0);
        check("rst_m_cmd", m_cmd0, 0);
        check("rst_m_ch", m_ch0, 0);
        check("rst_err", err0, 0);
        check("rst_err_cnt", err_cnt0, 0);
        check("rst_cmd_ready", cmd_ready0, 0);
        check("rst_wready", wready0, 0);
        check("rst_wvalid", m_wvalid0, 0);
        check("rst_fp_cmd_valid", m_cmd_valid1, 0);
        ph = P_IDLE; mptr = 0; mch = 0; mcnt = 0; merr = 1'b0; mcmd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] st_cmd;
        int n;

        do_reset();

        // Single read on channel 2.
        queue_cmd(2, 1'b0, 0, -1);
        cr_mode = 2;
        drive();
        #1;
        check("rd_ready", cmd_ready0, 4'b0100);
        cycle();
        check("rd_cmd_valid", m_cmd_valid0, 1);
        check("rd_ch", m_ch0, 2);
        cr_mode = 1;
        cycle();
        check("rd_busy_drop", busy0, 0);

        // Write burst of 4 beats on channel 1 with toggling backpressure.
        obs_beats = 0; obs_eop_at = 0;
        queue_cmd(1, 1'b1, 4, -1);
        wr_mode = 3; wv_pct = 100;
        drain("wr_drain", 40);
        check("wr_beats", obs_beats, 4);
        check("wr_eop_at", obs_eop_at, 4);
        wr_mode = 1;

        // Fairness: all channels request reads continuously.
        do_reset();
        for (int c = 0; c < NC; c++) queue_cmd(c, 1'b0, 0, -1);
        pol_fair = 1; fair_k = 0; cr_mode = 1;
        repeat (32) cycle();
        check("rr_grants", fair_k, 16);
        pol_fair = 0;
        drain("fair_drain", 40);

        // Command stall: payload held, other requests wait.
        queue_cmd(1, 1'b0, 0, -1);
        cr_mode = 2;
        cycle();
        st_cmd = c_cmd[1];
        queue_cmd(3, 1'b0, 0, -1);
        for (int i = 0; i < 10; i++) begin
            drive();
            #1;
            check("stall_cmd", m_cmd0, st_cmd);
            check("stall_ch", m_ch0, 1);
            check("stall_valid", m_cmd_valid0, 1);
            check("stall_no_accept", cmd_ready0, 0);
            cycle();
        end
        cr_mode = 1;
        drain("stall_drain", 40);

        // Protocol error: extra sop on the second beat of three.
        do_reset();
        obs_beats = 0; obs_err = 0;
        queue_cmd(0, 1'b1, 3, 1);
        drain("err_drain", 40);
        cycle();
        check("err_pulses", obs_err, 1);
        check("err_cnt_one", err_cnt0, 1);
        check("err_beats", obs_beats, 3);

        // 300 single-beat bursts missing sop saturate the counter.
        for (int k = 0; k < 300; k++) begin
            queue_cmd(k % NC, 1'b1, 1, 0);
            drain("err_sat_drain", 20);
        end
        cycle();
        check("err_cnt_sat", err_cnt0, 255);

        // Randomized mixed traffic.
        do_reset();
        pol_rand = 1; cr_mode = 0; wr_mode = 0; wv_pct = 70;
        repeat (3000) cycle();
        pol_rand = 0;
        drain("rand_drain", 3000);

        // Reset in the middle of a 5-beat burst.
        cr_mode = 1; wr_mode = 1; wv_pct = 100;
        queue_cmd(1, 1'b1, 5, -1);
        n = 0;
        while (bi[1] < 2 && n < 20) begin
            cycle();
            n++;
        end
        check("mid_beats", bi[1], 2);
        do_reset();
        queue_cmd(3, 1'b0, 0, -1);
        queue_cmd(0, 1'b0, 0, -1);
        drive();
        #1;
        check("post_rst_grant", cmd_ready0, 4'b0001);
        drain("post_rst_drain", 40);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
